thread_sched: RTL and testbench

Round-robin thread scheduler for sha512unit and related cores: the parametrised, stateful successor of the combinational next-thread-number function. It keeps a per-thread ready bitmap and a registered round-robin pointer that walks thread numbers in the canonical order. It issues one ready thread at a time to the core over a valid/accept handshake. Context count per core and sequence count are generalised, and a strict/relaxed selection mode is added.

---
 rtl/thread_sched.sv | 175 +++++++++++++++++
 tb/tb_thread_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_sched.sv
// thread_sched: round-robin thread scheduler with ready bitmap.
// Issues one ready thread at a time over a valid/accept handshake.
//
// Ports:
//   CLK, rst_n    clock, async active-low reset
//   strict        1: only ptr may issue; 0: first ready at/after ptr
//   set_en/num    mark thread {core_ctx, seq} ready
//   issue_valid   issue_num is offered to the core
//   issue_num     offered thread
//   issue_rd      core accepts the offer
//   ptr           round-robin pointer
//   ready_count   number of ready threads
//   err           sticky bad-set flag
module thread_sched #(
  parameter int N_CORES = 4,
  parameter int N_CTX   = 2,
  parameter int N_SEQ   = 2,
  localparam int N_CC      = N_CORES * N_CTX,
  localparam int N_THREADS = N_CC * N_SEQ,
  localparam int CC_MSB  = (N_CC > 1) ? $clog2(N_CC) - 1 : 0,
  localparam int SEQ_MSB = $clog2(N_SEQ) - 1,
  localparam int TH_MSB  = CC_MSB + SEQ_MSB + 1,
  localparam int RC_MSB  = $clog2(N_THREADS + 1) - 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              strict,
  input  logic              set_en,
  input  logic [TH_MSB:0]   set_num,
  output logic              issue_valid,
  output logic [TH_MSB:0]   issue_num,
  input  logic              issue_rd,
  output logic [TH_MSB:0]   ptr,
  output logic [RC_MSB:0]   ready_count,
  output logic              err
);

  localparam int TW     = TH_MSB + 1;
  localparam int SW     = SEQ_MSB + 1;
  localparam int CCW    = CC_MSB + 1;
  localparam int RCW    = RC_MSB + 1;
  localparam int NT_PAD = 1 << TW;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_OFFER,
    S_BUBBLE
  } state_e;

  state_e            state_q, state_d;
  logic [NT_PAD-1:0] ready_q, ready_d;
  logic [TW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     num_q, num_d;
  logic              valid_q, valid_d;
  logic [RCW-1:0]    cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              hit_found;
  logic [TW-1:0]     hit_num;
  logic [TW-1:0]     cur;
  logic              accept;
  logic              cc_ok;
  logic              same_x;
  logic              eff_set;

  // Canonical order: core_ctx fastest, seq advances on core_ctx wrap.
  function automatic logic [TW-1:0] nxt(input logic [TW-1:0] t);
    logic [CCW-1:0] cc;
    logic [SW-1:0]  sq;
    cc = t[TW-1:SW];
    sq = t[SW-1:0];
    if (cc == CCW'(N_CC - 1)) begin
      cc = '0;
      sq = sq + 1'b1;
    end else begin
      cc = cc + 1'b1;
    end
    return {cc, sq};
  endfunction

  // Single-cycle scan from ptr; strict mode looks at ptr only.
  always_comb begin
    hit_found = 1'b0;
    hit_num   = '0;
    cur       = ptr_q;
    if (strict) begin
      hit_found = ready_q[ptr_q];
      hit_num   = ptr_q;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (!hit_found && ready_q[cur]) begin
          hit_found = 1'b1;
          hit_num   = cur;
        end
        cur = nxt(cur);
      end
    end
  end

  assign accept = (state_q == S_OFFER) && issue_rd;
  assign cc_ok  = set_num[TW-1:SW] <= CCW'(N_CC - 1);
  assign same_x = accept && (set_num == num_q);

  // A set of the thread being accepted counts as effective: set wins.
  assign eff_set = set_en && cc_ok &&
                   (!ready_q[set_num] || same_x);

  always_comb begin
    ready_d = ready_q;
    if (accept) begin
      ready_d[num_q] = 1'b0;
    end
    if (eff_set) begin
      ready_d[set_num] = 1'b1;
    end
    cnt_d = cnt_q + RCW'(eff_set) - RCW'(accept);
    err_d = err_q | (set_en && !eff_set);
    ptr_d = accept ? nxt(num_q) : ptr_q;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    num_d   = num_q;
    unique case (state_q)
      S_SEARCH: begin
        if (hit_found) begin
          valid_d = 1'b1;
          num_d   = hit_num;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (issue_rd) begin
          valid_d = 1'b0;
          state_d = S_BUBBLE;
        end
      end
      S_BUBBLE: begin
        state_d = S_SEARCH;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_SEARCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SEARCH;
      ready_q <= '0;
      ptr_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign issue_valid = valid_q;
  assign issue_num   = num_q;
  assign ptr         = ptr_q;
  assign ready_count = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_thread_sched.sv
// tb_thread_sched: directed bench for thread_sched.
// Main DUT N_CC=8, N_SEQ=2; second DUT N_CC=6.
module tb_thread_sched;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       strict;
  logic       set_en;
  logic [3:0] set_num;
  logic       issue_rd;
  logic       issue_valid;
  logic [3:0] issue_num;
  logic [3:0] ptr;
  logic [4:0] ready_count;
  logic       err;

  logic       set_en6;
  logic [3:0] set_num6;
  logic       issue_rd6;
  logic       iv6;
  logic [3:0] inum6;
  logic [3:0] ptr6;
  logic [3:0] rc6;
  logic       err6;

  int n_cmp = 0;
  int n_bad = 0;

  thread_sched #(
    .N_CORES(4), .N_CTX(2), .N_SEQ(2)
  ) u_dut (
    .CLK(clk), .rst_n(rst_n), .strict(strict),
    .set_en(set_en), .set_num(set_num),
    .issue_valid(issue_valid), .issue_num(issue_num),
    .issue_rd(issue_rd), .ptr(ptr),
    .ready_count(ready_count), .err(err)
  );

  thread_sched #(
    .N_CORES(3), .N_CTX(2), .N_SEQ(2)
  ) u_dut6 (
    .CLK(clk), .rst_n(rst_n), .strict(strict),
    .set_en(set_en6), .set_num(set_num6),
    .issue_valid(iv6), .issue_num(inum6),
    .issue_rd(issue_rd6), .ptr(ptr6),
    .ready_count(rc6), .err(err6)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    issue_rd = 1'b1;
    tick();
    issue_rd = 1'b0;
  endtask

  task automatic set1(input logic [3:0] n);
    set_en  = 1'b1;
    set_num = n;
    tick();
    set_en  = 1'b0;
  endtask

  task automatic set6(input logic [3:0] n);
    set_en6  = 1'b1;
    set_num6 = n;
    tick();
    set_en6  = 1'b0;
  endtask

  task automatic scen1(input string p);
    set_en  = 1'b1;
    set_num = 4'd0;
    tick();
    set_num = 4'd15;
    tick();
    set_en  = 1'b0;
    chk({p, "_v0"}, issue_valid, 1);
    chk({p, "_n0"}, issue_num, 0);
    chk({p, "_cnt2"}, ready_count, 2);
    accept();
    chk({p, "_bub"}, issue_valid, 0);
    chk({p, "_ptr2"}, ptr, 2);
    chk({p, "_cnt1"}, ready_count, 1);
    tick();
    chk({p, "_srch"}, issue_valid, 0);
    tick();
    chk({p, "_v15"}, issue_valid, 1);
    chk({p, "_n15"}, issue_num, 15);
    accept();
    chk({p, "_ptr0"}, ptr, 0);
    chk({p, "_cnt0"}, ready_count, 0);
    chk({p, "_vend"}, issue_valid, 0);
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b1;
    strict    = 1'b0;
    set_en    = 1'b0;
    set_num   = '0;
    issue_rd  = 1'b0;
    set_en6   = 1'b0;
    set_num6  = '0;
    issue_rd6 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", issue_valid, 0);
    chk("rst_num", issue_num, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_cnt", ready_count, 0);
    chk("rst_err", err, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // accept with nothing offered is ignored
    accept();
    chk("idle_rd_ptr", ptr, 0);
    chk("idle_rd_cnt", ready_count, 0);

    // N_CC=6 instance: out-of-range and wrap
    set6(4'hF);
    chk("d6_err", err6, 1);
    chk("d6_cnt0", rc6, 0);
    tick();
    tick();
    chk("d6_noissue", iv6, 0);
    set6(4'd3);
    chk("d6_cnt1", rc6, 1);
    tick();
    chk("d6_v3", iv6, 1);
    chk("d6_n3", inum6, 3);
    issue_rd6 = 1'b1;
    tick();
    issue_rd6 = 1'b0;
    chk("d6_ptr5", ptr6, 5);
    set6(4'd10);
    tick();
    chk("d6_n10", inum6, 10);
    issue_rd6 = 1'b1;
    tick();
    issue_rd6 = 1'b0;
    chk("d6_ptr_wrap", ptr6, 1);
    chk("d6_cnt_end", rc6, 0);
    chk("d6_err_stk", err6, 1);

    // scenario 1
    scen1("s1");

    // scenario 2: strict
    strict = 1'b1;
    set1(4'd2);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (issue_valid !== 1'b0) ok = 1'b0;
    end
    chk("s2_strict_hold", ok, 1);
    set1(4'd0);
    tick();
    chk("s2_v0", issue_valid, 1);
    chk("s2_n0", issue_num, 0);
    accept();
    chk("s2_ptr2", ptr, 2);
    tick();
    tick();
    chk("s2_n2", issue_num, 2);
    chk("s2_v2", issue_valid, 1);
    accept();
    chk("s2_ptr4", ptr, 4);
    strict = 1'b0;

    // scenario 3: held offer
    set1(4'd4);
    tick();
    chk("s3_n4", issue_num, 4);
    accept();
    chk("s3_ptr6", ptr, 6);
    set1(4'd6);
    tick();
    chk("s3_v6", issue_valid, 1);
    chk("s3_n6", issue_num, 6);
    set_en  = 1'b1;
    set_num = 4'd4;
    tick();
    set_en  = 1'b0;
    ok = (issue_num === 4'd6) && issue_valid;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (issue_num !== 4'd6 || issue_valid !== 1'b1)
        ok = 1'b0;
    end
    chk("s3_stable", ok, 1);
    chk("s3_cnt2", ready_count, 2);
    accept();
    chk("s3_ptr8", ptr, 8);
    chk("s3_cnt1", ready_count, 1);
    tick();
    tick();
    chk("s3_n4b", issue_num, 4);
    accept();
    chk("s3_ptr6b", ptr, 6);

    // scenario 4: set and accept same thread
    set1(4'd5);
    tick();
    chk("s4_n5", issue_num, 5);
    set_en   = 1'b1;
    set_num  = 4'd5;
    issue_rd = 1'b1;
    tick();
    set_en   = 1'b0;
    issue_rd = 1'b0;
    chk("s4_cnt", ready_count, 1);
    chk("s4_ptr7", ptr, 7);
    chk("s4_err", err, 0);
    chk("s4_bub", issue_valid, 0);
    tick();
    tick();
    chk("s4_rev", issue_valid, 1);
    chk("s4_ren", issue_num, 5);
    accept();
    chk("s4_cnt0", ready_count, 0);

    // scenario 5: double set
    set1(4'd3);
    set1(4'd3);
    chk("s5_err", err, 1);
    chk("s5_cnt1", ready_count, 1);
    chk("s5_n3", issue_num, 3);
    accept();
    chk("s5_cnt0", ready_count, 0);
    chk("s5_ptr5", ptr, 5);

    // scenario 6: reset mid-offer
    set1(4'd1);
    tick();
    chk("s6_v1", issue_valid, 1);
    chk("s6_n1", issue_num, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rvalid", issue_valid, 0);
    chk("s6_rnum", issue_num, 0);
    chk("s6_rptr", ptr, 0);
    chk("s6_rcnt", ready_count, 0);
    chk("s6_rerr", err, 0);
    chk("s6_rerr6", err6, 0);
    tick();
    rst_n = 1'b1;
    scen1("s6r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
